// File: rtl/otter_ifq_pkg.sv
// -----------------------------------------------------------------------------
// otter_ifq_pkg
// Shared types and constants for the instruction fetch queue.
//   ifq_state_t : fetch FSM states (IDLE / REQ / WAIT)
//   ifq_entry_t : one queued fetch result {pc, instr, misalign}
//   IFQ_NOP     : instruction substituted for a misaligned fetch (addi x0,x0,0)
// Optional feature macro: IFQ_MISALIGN_CHECK_EN (see ifetch_queue).
// -----------------------------------------------------------------------------
package otter_ifq_pkg;

    typedef enum logic [1:0] {
        IFQ_IDLE = 2'd0,
        IFQ_REQ  = 2'd1,
        IFQ_WAIT = 2'd2
    } ifq_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        misalign;
    } ifq_entry_t;

    localparam logic [31:0] IFQ_NOP = 32'h0000_0013;

    // Memory is word addressed on the bus; low address bits are always zero.
    function automatic logic [31:0] ifq_word_addr(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// -----------------------------------------------------------------------------
// ifq_fifo
// Register-based first-word-fall-through FIFO of ifq_entry_t.
//   clk, rst_n      : clock, asynchronous active-low reset
//   push_i          : write push_entry_i at the tail
//   push_entry_i    : entry to write
//   pop_i           : discard the head entry (caller guarantees not empty)
//   flush_i         : empty the FIFO; wins over push and pop
//   head_o          : current head entry (meaningful only when count_o != 0)
//   count_o         : number of valid entries, 0..DEPTH
// Pointers wrap naturally because DEPTH is a power of two.
// -----------------------------------------------------------------------------
module ifq_fifo
    import otter_ifq_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  ifq_entry_t    push_entry_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output ifq_entry_t    head_o,
    output logic [CW-1:0] count_o
);

    ifq_entry_t    mem_q [DEPTH];
    ifq_entry_t    mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = push_entry_i;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// -----------------------------------------------------------------------------
// ifetch_queue
// Instruction fetch front end: accepts a PC, issues a single instruction
// memory read, and queues {pc, instr} for decode in a small FWFT FIFO.
//
// Ports:
//   CLK, IFQ_RST_N                 : clock, asynchronous active-low reset
//   IFQ_PC_IN/_VALID/_READY        : fetch address handshake (READY = PC load enable)
//   IFQ_FLUSH                      : redirect; drops queue and in-flight response
//   IFQ_MEM_ADDR/_REQ, IFQ_MEM_GNT : memory request, held until granted
//   IFQ_MEM_RVALID/_RDATA          : memory response
//   IFQ_INSTR_OUT/_PC_OUT/_VALID   : head of queue to decode
//   IFQ_INSTR_READY                : decode consumes the head
//   IFQ_MISALIGN_OUT               : head is a NOP substituted for a misaligned PC
//                                    (only with IFQ_MISALIGN_CHECK_EN)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1; ready never depends on valid, and the request side (MEM_REQ/ADDR)
// never changes while waiting for its grant.
//
// Optional feature: define IFQ_MISALIGN_CHECK_EN to turn a PC with nonzero
// bits [1:0] into a queued NOP flagged misaligned, with no memory access.
// Without it the low address bits are simply forced to zero on the bus.
// -----------------------------------------------------------------------------
module ifetch_queue
    import otter_ifq_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        CLK,
    input  logic        IFQ_RST_N,
    input  logic [31:0] IFQ_PC_IN,
    input  logic        IFQ_PC_VALID,
    output logic        IFQ_PC_READY,
    input  logic        IFQ_FLUSH,
    output logic [31:0] IFQ_MEM_ADDR,
    output logic        IFQ_MEM_REQ,
    input  logic        IFQ_MEM_GNT,
    input  logic        IFQ_MEM_RVALID,
    input  logic [31:0] IFQ_MEM_RDATA,
    output logic [31:0] IFQ_INSTR_OUT,
    output logic [31:0] IFQ_INSTR_PC_OUT,
    output logic        IFQ_INSTR_VALID,
    input  logic        IFQ_INSTR_READY
`ifdef IFQ_MISALIGN_CHECK_EN
    ,
    output logic        IFQ_MISALIGN_OUT
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    ifq_state_t    state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic          mem_req_q, mem_req_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic          discard_q, discard_d;

    logic          pc_hs;
    logic          push;
    ifq_entry_t    push_entry;
    logic          pop;
    ifq_entry_t    head;
    logic [CW-1:0] fifo_count;
    logic          head_valid;

    assign head_valid   = (fifo_count != '0);
    assign IFQ_PC_READY = (state_q == IFQ_IDLE) && !IFQ_FLUSH && (fifo_count < CW'(DEPTH));
    assign pc_hs        = IFQ_PC_VALID && IFQ_PC_READY;
    assign pop          = head_valid && IFQ_INSTR_READY;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        discard_d  = discard_q;
        push       = 1'b0;
        push_entry = '0;
        case (state_q)
            IFQ_IDLE: begin
                if (pc_hs) begin
                    pc_d = IFQ_PC_IN;
`ifdef IFQ_MISALIGN_CHECK_EN
                    if (IFQ_PC_IN[1:0] != 2'b00) begin
                        // Substituted NOP entry goes straight in; no bus traffic.
                        push       = 1'b1;
                        push_entry = '{pc: IFQ_PC_IN, instr: IFQ_NOP, misalign: 1'b1};
                    end else begin
                        state_d    = IFQ_REQ;
                        mem_req_d  = 1'b1;
                        mem_addr_d = ifq_word_addr(IFQ_PC_IN);
                    end
`else
                    state_d    = IFQ_REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = ifq_word_addr(IFQ_PC_IN);
`endif
                end
            end
            IFQ_REQ: begin
                // The request stays up through a flush; only its response is dropped.
                if (IFQ_MEM_GNT) begin
                    state_d   = IFQ_WAIT;
                    mem_req_d = 1'b0;
                end
                if (IFQ_FLUSH) begin
                    discard_d = 1'b1;
                end
            end
            IFQ_WAIT: begin
                if (IFQ_MEM_RVALID) begin
                    state_d   = IFQ_IDLE;
                    discard_d = 1'b0;
                    if (!discard_q && !IFQ_FLUSH) begin
                        push       = 1'b1;
                        push_entry = '{pc: pc_q, instr: IFQ_MEM_RDATA, misalign: 1'b0};
                    end
                end else if (IFQ_FLUSH) begin
                    discard_d = 1'b1;
                end
            end
            default: begin
                state_d = IFQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge IFQ_RST_N) begin
        if (!IFQ_RST_N) begin
            state_q    <= IFQ_IDLE;
            pc_q       <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            discard_q  <= discard_d;
        end
    end

    ifq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (CLK),
        .rst_n        (IFQ_RST_N),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .flush_i      (IFQ_FLUSH),
        .head_o       (head),
        .count_o      (fifo_count)
    );

    assign IFQ_MEM_REQ      = mem_req_q;
    assign IFQ_MEM_ADDR     = mem_addr_q;
    assign IFQ_INSTR_VALID  = head_valid;
    assign IFQ_INSTR_OUT    = head.instr;
    assign IFQ_INSTR_PC_OUT = head.pc;

`ifdef IFQ_MISALIGN_CHECK_EN
    assign IFQ_MISALIGN_OUT = head_valid && head.misalign;
`else
    logic unused_misalign;
    assign unused_misalign = head.misalign;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic [31:0] instr_out;
  logic [31:0] instr_pc_out;
  logic        instr_valid;
  logic        instr_ready;
`ifdef IFQ_MISALIGN_CHECK_EN
  logic        misalign_out;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state (spec-level view of the fetch engine)
  logic [63:0] exp_q[$];   // {pc, instr}
  int          ph;         // 0 idle, 1 request outstanding, 2 awaiting data
  logic        discard;
  logic [31:0] cur_pc;
  int          wait_cnt;

  ifetch_queue #(.DEPTH(DEPTH)) dut (
    .CLK              (clk),
    .IFQ_RST_N        (rst_n),
    .IFQ_PC_IN        (pc_in),
    .IFQ_PC_VALID     (pc_valid),
    .IFQ_PC_READY     (pc_ready),
    .IFQ_FLUSH        (flush),
    .IFQ_MEM_ADDR     (mem_addr),
    .IFQ_MEM_REQ      (mem_req),
    .IFQ_MEM_GNT      (gnt),
    .IFQ_MEM_RVALID   (rvalid),
    .IFQ_MEM_RDATA    (rdata),
    .IFQ_INSTR_OUT    (instr_out),
    .IFQ_INSTR_PC_OUT (instr_pc_out),
    .IFQ_INSTR_VALID  (instr_valid),
    .IFQ_INSTR_READY  (instr_ready)
`ifdef IFQ_MISALIGN_CHECK_EN
    ,
    .IFQ_MISALIGN_OUT (misalign_out)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic idle_inputs();
    pc_in = '0; pc_valid = 0; flush = 0; gnt = 0; rvalid = 0; rdata = '0; instr_ready = 0;
  endtask

  // Full fetch with immediate grant and response; returns at the negedge
  // after the response edge (entry visible).
  task automatic do_fetch(input logic [31:0] pc, input logic [31:0] data);
    @(negedge clk); pc_in = pc; pc_valid = 1;
    @(negedge clk); pc_valid = 0; gnt = 1;
    @(negedge clk); gnt = 0; rvalid = 1; rdata = data;
    @(negedge clk); rvalid = 0;
  endtask

  task automatic drain();
    instr_ready = 1;
    repeat (DEPTH + 1) @(negedge clk);
    instr_ready = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #3;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %0h expected 0", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %0h expected 0", instr_valid); end
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1;
    checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL reset_pc_ready: got %0h expected 1", pc_ready); end
  endtask

  task automatic test_latency();
    @(negedge clk); pc_in = 32'h100; pc_valid = 1; #1;
    checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL lat_pc_ready: got %0h expected 1", pc_ready); end
    @(negedge clk); pc_valid = 0; gnt = 1; #1;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL lat_mem_req: got %0h expected 1", mem_req); end
    checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL lat_mem_addr: got %h expected 00000100", mem_addr); end
    @(negedge clk); gnt = 0; rvalid = 1; rdata = 32'h0050_0093; #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL lat_req_drop: got %0h expected 0", mem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL lat_early_valid: got %0h expected 0", instr_valid); end
    @(negedge clk); rvalid = 0; #1;
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL lat_valid: got %0h expected 1", instr_valid); end
    checks++; if (instr_out !== 32'h0050_0093) begin errors++; $display("FAIL lat_instr: got %h expected 00500093", instr_out); end
    checks++; if (instr_pc_out !== 32'h100) begin errors++; $display("FAIL lat_instr_pc: got %h expected 00000100", instr_pc_out); end
    instr_ready = 1;
    @(negedge clk); instr_ready = 0; #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL lat_pop: got %0h expected 0", instr_valid); end
  endtask

  task automatic test_full();
    instr_ready = 0;
    do_fetch(32'h0, 32'h1111_1111);
    do_fetch(32'h4, 32'h2222_2222);
    #1;
    checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL full_pc_ready: got %0h expected 0", pc_ready); end
    checks++; if (instr_pc_out !== 32'h0) begin errors++; $display("FAIL full_head0_pc: got %h expected 00000000", instr_pc_out); end
    checks++; if (instr_out !== 32'h1111_1111) begin errors++; $display("FAIL full_head0_instr: got %h expected 11111111", instr_out); end
    instr_ready = 1;
    @(negedge clk); #1;
    checks++; if (instr_pc_out !== 32'h4) begin errors++; $display("FAIL full_head1_pc: got %h expected 00000004", instr_pc_out); end
    checks++; if (instr_out !== 32'h2222_2222) begin errors++; $display("FAIL full_head1_instr: got %h expected 22222222", instr_out); end
    @(negedge clk); instr_ready = 0; #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL full_empty: got %0h expected 0", instr_valid); end
    checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL full_pc_ready_back: got %0h expected 1", pc_ready); end
  endtask

  task automatic test_gnt_delay();
    @(negedge clk); pc_in = 32'h200; pc_valid = 1;
    @(negedge clk); pc_valid = 0; pc_in = 32'hFFFF_FFF0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL gnt_delay_req[%0d]: got %0h expected 1", i, mem_req); end
      checks++; if (mem_addr !== 32'h200) begin errors++; $display("FAIL gnt_delay_addr[%0d]: got %h expected 00000200", i, mem_addr); end
      @(negedge clk);
    end
    gnt = 1;
    @(negedge clk); gnt = 0; rvalid = 1; rdata = 32'hA5A5_0001; #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL gnt_delay_req_drop: got %0h expected 0", mem_req); end
    @(negedge clk); rvalid = 0; #1;
    checks++; if (instr_out !== 32'hA5A5_0001) begin errors++; $display("FAIL gnt_delay_instr: got %h expected a5a50001", instr_out); end
    drain();
  endtask

  task automatic test_flush_wait();
    @(negedge clk); pc_in = 32'h300; pc_valid = 1;
    @(negedge clk); pc_valid = 0; gnt = 1;
    @(negedge clk); gnt = 0; flush = 1; #1;
    checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL flush_wait_ready_in_flush: got %0h expected 0", pc_ready); end
    @(negedge clk); flush = 0; #1;
    checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL flush_wait_ready_pending: got %0h expected 0", pc_ready); end
    @(negedge clk); rvalid = 1; rdata = 32'hDEAD_BEEF;
    @(negedge clk); rvalid = 0; #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL flush_wait_no_push: got %0h expected 0", instr_valid); end
    checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL flush_wait_idle: got %0h expected 1", pc_ready); end
    @(negedge clk); #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL flush_wait_still_empty: got %0h expected 0", instr_valid); end
  endtask

  task automatic test_flush_fifo();
    do_fetch(32'h400, 32'h0000_0400);
    #1;
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL flush_fifo_pre: got %0h expected 1", instr_valid); end
    flush = 1; instr_ready = 1;
    @(negedge clk); flush = 0; instr_ready = 0; #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL flush_fifo_empty: got %0h expected 0", instr_valid); end
    checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL flush_fifo_ready: got %0h expected 1", pc_ready); end
  endtask

  task automatic test_flush_gnt();
    @(negedge clk); pc_in = 32'h480; pc_valid = 1;
    @(negedge clk); pc_valid = 0; gnt = 1; flush = 1;
    @(negedge clk); gnt = 0; flush = 0; rvalid = 1; rdata = 32'h1234_5678;
    @(negedge clk); rvalid = 0; #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL flush_gnt_no_push: got %0h expected 0", instr_valid); end
    checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL flush_gnt_idle: got %0h expected 1", pc_ready); end
  endtask

  task automatic test_reset_async();
    do_fetch(32'h500, 32'h0000_0500);
    @(negedge clk); pc_in = 32'h504; pc_valid = 1;
    @(negedge clk); pc_valid = 0; #1;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL arst_pre_req: got %0h expected 1", mem_req); end
    #2 rst_n = 0;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL arst_mem_req: got %0h expected 0", mem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL arst_instr_valid: got %0h expected 0", instr_valid); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL arst_mem_addr: got %h expected 0", mem_addr); end
    @(negedge clk); rst_n = 1;
    @(negedge clk); rvalid = 1; rdata = 32'hBAD0_0BAD;
    @(negedge clk); rvalid = 0; #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL arst_late_rvalid: got %0h expected 0", instr_valid); end
    checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL arst_idle: got %0h expected 1", pc_ready); end
  endtask

`ifdef IFQ_MISALIGN_CHECK_EN
  task automatic test_misalign();
    @(negedge clk); pc_in = 32'h102; pc_valid = 1;
    @(negedge clk); pc_valid = 0; #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL misalign_no_req: got %0h expected 0", mem_req); end
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL misalign_valid: got %0h expected 1", instr_valid); end
    checks++; if (instr_out !== 32'h0000_0013) begin errors++; $display("FAIL misalign_nop: got %h expected 00000013", instr_out); end
    checks++; if (instr_pc_out !== 32'h102) begin errors++; $display("FAIL misalign_pc: got %h expected 00000102", instr_pc_out); end
    checks++; if (misalign_out !== 1'b1) begin errors++; $display("FAIL misalign_flag: got %0h expected 1", misalign_out); end
    drain();
  endtask
`else
  task automatic test_addr_align();
    @(negedge clk); pc_in = 32'h106; pc_valid = 1;
    @(negedge clk); pc_valid = 0; gnt = 1; #1;
    checks++; if (mem_addr !== 32'h104) begin errors++; $display("FAIL align_mem_addr: got %h expected 00000104", mem_addr); end
    @(negedge clk); gnt = 0; rvalid = 1; rdata = 32'h0000_0106;
    @(negedge clk); rvalid = 0; #1;
    checks++; if (instr_pc_out !== 32'h106) begin errors++; $display("FAIL align_instr_pc: got %h expected 00000106", instr_pc_out); end
    drain();
  endtask
`endif

  task automatic test_random();
    logic hs, pop, push;
    exp_q.delete(); ph = 0; discard = 0; cur_pc = '0; wait_cnt = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      pc_valid    = ($urandom_range(0, 1) == 1);
      pc_in       = $urandom() & 32'hFFFF_FFFC;
      instr_ready = ($urandom_range(0, 1) == 1);
      flush       = ($urandom_range(0, 15) == 0);
      gnt         = (ph == 1) && ($urandom_range(0, 1) == 1);
      rvalid      = (ph == 2) ? (wait_cnt == 0) : ($urandom_range(0, 7) == 0);
      rdata       = $urandom();
      #1;
      checks++; if (instr_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL rnd_valid@%0d: got %0h expected %0h", cyc, instr_valid, exp_q.size() != 0); end
      if (exp_q.size() != 0) begin
        checks++; if ({instr_pc_out, instr_out} !== exp_q[0]) begin errors++; $display("FAIL rnd_head@%0d: got %h expected %h", cyc, {instr_pc_out, instr_out}, exp_q[0]); end
      end
      checks++; if (pc_ready !== (ph == 0 && !flush && exp_q.size() < DEPTH)) begin errors++; $display("FAIL rnd_pc_ready@%0d: got %0h expected %0h", cyc, pc_ready, (ph == 0 && !flush && exp_q.size() < DEPTH)); end
      checks++; if (mem_req !== (ph == 1)) begin errors++; $display("FAIL rnd_mem_req@%0d: got %0h expected %0h", cyc, mem_req, ph == 1); end
      if (ph == 1) begin
        checks++; if (mem_addr !== {cur_pc[31:2], 2'b00}) begin errors++; $display("FAIL rnd_mem_addr@%0d: got %h expected %h", cyc, mem_addr, {cur_pc[31:2], 2'b00}); end
      end
      // Advance model across the coming rising edge
      hs   = pc_valid && ph == 0 && !flush && exp_q.size() < DEPTH;
      pop  = exp_q.size() != 0 && instr_ready;
      push = ph == 2 && rvalid && !discard && !flush;
      if (flush) exp_q.delete();
      else begin
        if (pop) void'(exp_q.pop_front());
        if (push) exp_q.push_back({cur_pc, rdata});
      end
      case (ph)
        0: if (hs) begin ph = 1; cur_pc = pc_in; end
        1: begin
          if (flush) discard = 1;
          if (gnt) begin ph = 2; wait_cnt = $urandom_range(0, 3); end
        end
        default: begin
          if (rvalid) begin ph = 0; discard = 0; end
          else begin
            if (flush) discard = 1;
            wait_cnt--;
          end
        end
      endcase
    end
    @(negedge clk); idle_inputs();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_full();
    test_gnt_delay();
    test_flush_wait();
    test_flush_fifo();
    test_flush_gnt();
    test_reset_async();
`ifdef IFQ_MISALIGN_CHECK_EN
    test_misalign();
`else
    test_addr_align();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
